// File: rtl/traffic_phase_ctrl_pkg.sv
// rtl/traffic_phase_ctrl_pkg.sv - phase encodings, lamp constants and phase-order helper
package traffic_phase_ctrl_pkg;

  // 3-bit phase encodings
  localparam logic [2:0] PH_AG     = 3'd0;
  localparam logic [2:0] PH_AY     = 3'd1;
  localparam logic [2:0] PH_BG     = 3'd2;
  localparam logic [2:0] PH_BY     = 3'd3;
  localparam logic [2:0] PH_HOLDA  = 3'd4;
  localparam logic [2:0] PH_HOLDB  = 3'd5;
  localparam logic [2:0] PH_ALLRED = 3'd6;

  // Lamp groups are {red,yellow,green}, active high
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_AG     = PH_AG,
    S_AY     = PH_AY,
    S_BG     = PH_BG,
    S_BY     = PH_BY,
    S_HOLDA  = PH_HOLDA,
    S_HOLDB  = PH_HOLDB,
    S_ALLRED = PH_ALLRED
  } phase_t;

  // Successor in the normal AG -> AY -> BG -> BY ring; hold states re-enter at their green
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      S_AG:    next_phase = S_AY;
      S_AY:    next_phase = S_BG;
      S_BG:    next_phase = S_BY;
      S_BY:    next_phase = S_AG;
      S_HOLDB: next_phase = S_BG;
      default: next_phase = S_AG;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_bin2bcd99.sv
// rtl/traffic_phase_ctrl_bin2bcd99.sv - combinational 0..99 binary to 2-digit BCD, saturating at 99
module bin2bcd99 (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);

  logic [3:0] tens;
  logic [3:0] units;

  assign tens  = 4'(bin_i / 7'd10);
  assign units = 4'(bin_i - 7'(tens) * 7'd10);

  // Anything above 99 cannot be shown on two digits, so pin it to 99
  assign bcd_o = (bin_i > 7'd99) ? 8'h99 : {tens, units};

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road phase sequencer with stop/pause controls and BCD countdowns (option: TRAFFIC_GREEN_FLASH_EN)
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int unsigned GREEN_A = 30,
  parameter int unsigned GREEN_B = 20,
  parameter int unsigned YEL     = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       stopa,
  input  logic       stopb,
  input  logic       pause,
  output logic [2:0] light1,
  output logic [2:0] light2,
  output logic [7:0] bcd1,
  output logic [7:0] bcd2
);

  localparam logic [6:0] DUR_A = 7'(GREEN_A);
  localparam logic [6:0] DUR_B = 7'(GREEN_B);
  localparam logic [6:0] DUR_Y = 7'(YEL);

  phase_t     phase_q;
  logic [6:0] t_q;
  logic [6:0] disp1;
  logic [6:0] disp2;
  logic [6:0] t_plus_y;

  function automatic logic [6:0] dur_of(input phase_t p);
    case (p)
      S_AG:    dur_of = DUR_A;
      S_BG:    dur_of = DUR_B;
      default: dur_of = DUR_Y;
    endcase
  endfunction

  // Phase/timer sequencer: stops override everything, then release, then pause, then tick
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_q <= S_AG;
      t_q     <= DUR_A;
    end else if (stopa && stopb) begin
      phase_q <= S_ALLRED;
    end else if (stopa) begin
      phase_q <= S_HOLDA;
    end else if (stopb) begin
      phase_q <= S_HOLDB;
    end else begin
      case (phase_q)
        S_HOLDA, S_ALLRED, S_HOLDB: begin
          phase_q <= next_phase(phase_q);
          t_q     <= dur_of(next_phase(phase_q));
        end
        default: begin
          if (tick && !pause) begin
            if (t_q > 7'd1) begin
              t_q <= t_q - 7'd1;
            end else begin
              phase_q <= next_phase(phase_q);
              t_q     <= dur_of(next_phase(phase_q));
            end
          end
        end
      endcase
    end
  end

  assign t_plus_y = t_q + DUR_Y;

  // Lamp and countdown decode from the registered phase and timer
  always_comb begin
    light1 = L_RED;
    light2 = L_RED;
    disp1  = 7'd0;
    disp2  = 7'd0;
    case (phase_q)
      S_AG:    begin light1 = L_GRN; light2 = L_RED; disp1 = t_q;      disp2 = t_plus_y; end
      S_AY:    begin light1 = L_YEL; light2 = L_RED; disp1 = t_q;      disp2 = t_q;      end
      S_BG:    begin light1 = L_RED; light2 = L_GRN; disp1 = t_plus_y; disp2 = t_q;      end
      S_BY:    begin light1 = L_RED; light2 = L_YEL; disp1 = t_q;      disp2 = t_q;      end
      S_HOLDA: begin light1 = L_GRN; light2 = L_RED; end
      S_HOLDB: begin light1 = L_RED; light2 = L_GRN; end
      default: begin light1 = L_RED; light2 = L_RED; end
    endcase
`ifdef TRAFFIC_GREEN_FLASH_EN
    // Blank the active green on even seconds of the last three so it blinks at tick rate
    if ((t_q <= 7'd3) && !t_q[0]) begin
      if (phase_q == S_AG) light1 = light1 & ~L_GRN;
      if (phase_q == S_BG) light2 = light2 & ~L_GRN;
    end
`endif
  end

  bin2bcd99 u_bcd1 (
    .bin_i (disp1),
    .bcd_o (bcd1)
  );

  bin2bcd99 u_bcd2 (
    .bin_i (disp2),
    .bcd_o (bcd2)
  );

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       tick = 1'b0;
  logic       stopa = 1'b0;
  logic       stopb = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] light1, light2;
  logic [7:0] bcd1, bcd2;

  logic       clr_f = 1'b1;
  logic       tick_f = 1'b0;
  logic [2:0] f_light1, f_light2;
  logic [7:0] f_bcd1, f_bcd2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.GREEN_A(3), .GREEN_B(2), .YEL(1)) dut (
    .clk    (clk),
    .clr    (clr),
    .tick   (tick),
    .stopa  (stopa),
    .stopb  (stopb),
    .pause  (pause),
    .light1 (light1),
    .light2 (light2),
    .bcd1   (bcd1),
    .bcd2   (bcd2)
  );

  traffic_phase_ctrl #(.GREEN_A(5), .GREEN_B(2), .YEL(1)) dut_flash (
    .clk    (clk),
    .clr    (clr_f),
    .tick   (tick_f),
    .stopa  (1'b0),
    .stopb  (1'b0),
    .pause  (1'b0),
    .light1 (f_light1),
    .light2 (f_light2),
    .bcd1   (f_bcd1),
    .bcd2   (f_bcd2)
  );

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all(input string name, input logic [2:0] l1, input logic [2:0] l2,
                           input logic [7:0] b1, input logic [7:0] b2);
    total++;
    if (light1 !== l1 || light2 !== l2 || bcd1 !== b1 || bcd2 !== b2) begin
      bad++;
      $display("FAIL %s: got l1=%b l2=%b bcd1=%h bcd2=%h want l1=%b l2=%b bcd1=%h bcd2=%h",
               name, light1, light2, bcd1, bcd2, l1, l2, b1, b2);
    end
  endtask

  task automatic test_reset;
    step(2);
    total++;
    if (light1 !== 3'b001) begin bad++; $display("FAIL reset_light1: got %b want 001", light1); end
    total++;
    if (light2 !== 3'b100) begin bad++; $display("FAIL reset_light2: got %b want 100", light2); end
    total++;
    if (bcd1 !== 8'h03) begin bad++; $display("FAIL reset_bcd1: got %h want 03", bcd1); end
    total++;
    if (bcd2 !== 8'h04) begin bad++; $display("FAIL reset_bcd2: got %h want 04", bcd2); end
    clr = 1'b0;
    step(1);
    check_all("after_release_of_clr", 3'b001, 3'b100, 8'h03, 8'h04);
  endtask

  task automatic test_normal_cycle;
    do_tick(1);
    check_all("ag_t2", 3'b001, 3'b100, 8'h02, 8'h03);
    do_tick(2);
    check_all("ay_entry", 3'b010, 3'b100, 8'h01, 8'h01);
    do_tick(1);
    check_all("bg_entry", 3'b100, 3'b001, 8'h03, 8'h02);
    do_tick(1);
    check_all("bg_t1", 3'b100, 3'b001, 8'h02, 8'h01);
    do_tick(1);
    check_all("by_entry", 3'b100, 3'b010, 8'h01, 8'h01);
    do_tick(1);
    check_all("ag_wrap", 3'b001, 3'b100, 8'h03, 8'h04);
    // no tick: state must not move
    step(3);
    check_all("idle_no_tick", 3'b001, 3'b100, 8'h03, 8'h04);
  endtask

  task automatic test_pause;
    do_tick(1);
    check_all("pause_pre", 3'b001, 3'b100, 8'h02, 8'h03);
    pause = 1'b1;
    do_tick(2);
    check_all("pause_held", 3'b001, 3'b100, 8'h02, 8'h03);
    pause = 1'b0;
    step(1);
    check_all("pause_no_queue", 3'b001, 3'b100, 8'h02, 8'h03);
    do_tick(1);
    check_all("pause_release_tick", 3'b001, 3'b100, 8'h01, 8'h02);
  endtask

  task automatic test_stopa;
    do_tick(2);
    check_all("stopa_pre_bg", 3'b100, 3'b001, 8'h03, 8'h02);
    stopa = 1'b1;
    step(1);
    check_all("holda", 3'b001, 3'b100, 8'h00, 8'h00);
    do_tick(2);
    check_all("holda_ignores_tick", 3'b001, 3'b100, 8'h00, 8'h00);
    stopa = 1'b0;
    step(1);
    check_all("holda_release", 3'b001, 3'b100, 8'h03, 8'h04);
  endtask

  task automatic test_both_stops;
    stopa = 1'b1;
    stopb = 1'b1;
    step(1);
    check_all("allred", 3'b100, 3'b100, 8'h00, 8'h00);
    stopa = 1'b0;
    step(1);
    check_all("allred_to_holdb", 3'b100, 3'b001, 8'h00, 8'h00);
    stopb = 1'b0;
    step(1);
    check_all("holdb_release", 3'b100, 3'b001, 8'h03, 8'h02);
  endtask

  task automatic test_swap;
    stopa = 1'b1;
    step(1);
    check_all("swap_holda", 3'b001, 3'b100, 8'h00, 8'h00);
    stopa = 1'b0;
    stopb = 1'b1;
    step(1);
    check_all("swap_holdb", 3'b100, 3'b001, 8'h00, 8'h00);
    stopb = 1'b0;
    step(1);
    check_all("swap_release", 3'b100, 3'b001, 8'h03, 8'h02);
  endtask

  task automatic test_async_clr;
    do_tick(2);
    check_all("clr_pre_by", 3'b100, 3'b010, 8'h01, 8'h01);
    #2;
    clr = 1'b1;
    #1;
    check_all("clr_async", 3'b001, 3'b100, 8'h03, 8'h04);
    @(negedge clk);
    clr = 1'b0;
    step(1);
    check_all("clr_after", 3'b001, 3'b100, 8'h03, 8'h04);
  endtask

  task automatic test_flash;
    logic [4:0] want;
`ifdef TRAFFIC_GREEN_FLASH_EN
    want = 5'b11101;
`else
    want = 5'b11111;
`endif
    clr_f = 1'b0;
    step(1);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (f_light1[0] !== want[4-k] || f_light2 !== 3'b100 || f_light1[2:1] !== 2'b00) begin
        bad++;
        $display("FAIL flash_t%0d: got l1=%b l2=%b want green=%b l2=100", 5 - k, f_light1, f_light2, want[4-k]);
      end
      tick_f = 1'b1;
      @(negedge clk);
      tick_f = 1'b0;
      @(negedge clk);
    end
    total++;
    if (f_light1 !== 3'b010) begin bad++; $display("FAIL flash_ay: got %b want 010", f_light1); end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_pause();
    test_stopa();
    test_both_stops();
    test_swap();
    test_async_clr();
    test_flash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
